// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte-level write sequencer.
// Holds the bit-controller command encoding, the byte FSM state
// enum, the latched-byte payload and a helper for data-bit commands.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned CNT_W  = 3;

  // Command encoding understood by the bit controller.
  typedef enum logic [CMD_W-1:0] {
    BIT_IDLE   = 3'b000,
    BIT_START  = 3'b010,
    BIT_STOP   = 3'b011,
    BIT_DATA_0 = 3'b100,
    BIT_DATA_1 = 3'b101,
    BIT_ACK    = 3'b110,
    BIT_NACK   = 3'b111
  } bit_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_LOAD,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP,
    ST_DONE
  } state_e;

  // Byte currently being shifted out; the address phase reuses it with last=0.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } tx_byte_t;

  function automatic bit_cmd_e data_cmd(input logic b);
    return b ? BIT_DATA_1 : BIT_DATA_0;
  endfunction

endpackage

// File: rtl/i2c_bit_issuer.sv
// Owns the bit_go/bit_finish handshake with the bit controller.
// Ports:
//   clock, reset_n  - clock and async active-low reset
//   issue, command  - request from the byte FSM; taken only while bit_go=0
//   issued          - the current command finished this cycle (combinational)
//   bit_go          - registered command request to the bit controller
//   bit_command     - registered command, stable while bit_go=1
//   bit_finish      - completion from the bit controller; ignored while bit_go=0
module i2c_bit_issuer
  import i2c_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue,
  input  bit_cmd_e         command,
  output logic             issued,
  output logic             bit_go,
  output logic [CMD_W-1:0] bit_command,
  input  logic             bit_finish
);

  // bit_go drops the cycle after finish is seen; a request in that
  // low cycle raises it again, giving exactly one gap cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_go      <= 1'b0;
      bit_command <= BIT_IDLE;
    end else if (bit_go) begin
      if (bit_finish) begin
        bit_go      <= 1'b0;
        bit_command <= BIT_IDLE;
      end
    end else if (issue) begin
      bit_go      <= 1'b1;
      bit_command <= command;
    end
  end

  assign issued = bit_go & bit_finish;

endmodule

// File: rtl/i2c_master_byte.sv
// Byte-level I2C write sequencer feeding the bit controller.
// Frames START, 7-bit address + W, data bytes with per-byte ACK checks, STOP.
// Ports:
//   clock, reset_n      - clock and async active-low reset
//   start, addr         - begin a write to addr; ignored while busy
//   tx_data, tx_valid,
//   tx_last, tx_ready   - upstream byte stream; tx_ready is combinational
//                         (pulses in the LOAD cycle that takes the byte)
//   busy, done          - transaction in flight / one-cycle completion pulse
//   ack_error, underrun - status, valid with done, cleared by next start
//   bit_command, bit_go,
//   bit_finish, sda_in  - bit controller handshake and sampled SDA level
module i2c_master_byte
  import i2c_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              ack_error,
  output logic              underrun,
  output logic [CMD_W-1:0]  bit_command,
  output logic              bit_go,
  input  logic              bit_finish,
  input  logic              sda_in
);

  state_e           state_q, state_d;
  tx_byte_t         byte_q, byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_error_d, underrun_d;
  logic             issue, issued;
  bit_cmd_e         command;

  i2c_bit_issuer u_issuer (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue       (issue),
    .command     (command),
    .issued      (issued),
    .bit_go      (bit_go),
    .bit_command (bit_command),
    .bit_finish  (bit_finish)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      ack_error <= ack_error_d;
      underrun  <= underrun_d;
    end
  end

  // Next-state and command selection. Command states keep issue high;
  // the issuer only takes it in the gap cycle after the previous finish.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    ack_error_d = ack_error;
    underrun_d  = underrun;
    issue       = 1'b0;
    command     = BIT_IDLE;
    tx_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          issue       = 1'b1;
          command     = BIT_START;
          byte_d.data = {addr, 1'b0};
          byte_d.last = 1'b0;
          cnt_d       = CNT_W'(DATA_W - 1);
          ack_error_d = 1'b0;
          underrun_d  = 1'b0;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        issue   = 1'b1;
        command = BIT_START;
        if (issued) begin
          state_d = ST_ADDR;
        end
      end

      ST_ADDR, ST_DATA: begin
        issue   = 1'b1;
        command = data_cmd(byte_q.data[cnt_q]);
        if (issued) begin
          if (cnt_q == '0) begin
            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      // NACK releases SDA so the slave can drive its acknowledge.
      ST_ADDR_ACK, ST_DATA_ACK: begin
        issue   = 1'b1;
        command = BIT_NACK;
        if (issued) begin
          if (sda_in) begin
            ack_error_d = 1'b1;
            state_d     = ST_STOP;
          end else if (state_q == ST_DATA_ACK && byte_q.last) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      // LOAD sits in the gap cycle, so it issues the next command directly.
      ST_LOAD: begin
        issue = 1'b1;
        if (tx_valid) begin
          tx_ready    = 1'b1;
          byte_d.data = tx_data;
          byte_d.last = tx_last;
          cnt_d       = CNT_W'(DATA_W - 1);
          command     = data_cmd(tx_data[DATA_W-1]);
          state_d     = ST_DATA;
        end else begin
          underrun_d = 1'b1;
          command    = BIT_STOP;
          state_d    = ST_STOP;
        end
      end

      ST_STOP: begin
        issue   = 1'b1;
        command = BIT_STOP;
        if (issued) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Scoreboard bench for i2c_master_byte: a transaction-level model pushes the
// expected command stream and status; a monitor pops and compares them.
module tb_i2c_master_byte;

  localparam logic [2:0] C_START = 3'b010;
  localparam logic [2:0] C_STOP  = 3'b011;
  localparam logic [2:0] C_D0    = 3'b100;
  localparam logic [2:0] C_D1    = 3'b101;
  localparam logic [2:0] C_NACK  = 3'b111;

  typedef struct {
    bit ack_err;
    bit underrun;
    int readies;
  } res_t;

  logic       clock, reset_n, start;
  logic [6:0] addr;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_ready;
  logic       busy, done, ack_error, underrun;
  logic [2:0] bit_command;
  logic       bit_go, bit_finish, sda_in;

  i2c_master_byte dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .addr        (addr),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .ack_error   (ack_error),
    .underrun    (underrun),
    .bit_command (bit_command),
    .bit_go      (bit_go),
    .bit_finish  (bit_finish),
    .sda_in      (sda_in)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input bit ok, input string name,
                                input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Shared transaction setup, written by the main process only.
  logic [7:0] txn_bytes[$];
  int         src_avail = 0;
  int         nack_at   = -1;
  int         latency   = 4;
  bit         spurious  = 1'b0;
  bit         src_clear = 1'b0;
  bit         mon_en    = 1'b0;

  logic [2:0] exp_cmd_q[$];
  res_t       exp_res_q[$];

  // Upstream byte source: presents bytes in order, first src_avail valid.
  int idx = 0;
  int rdy_cnt = 0;
  initial begin
    bit acc;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    forever begin
      @(negedge clock);
      acc = tx_ready;
      @(posedge clock);
      #1;
      if (src_clear) begin
        idx = 0;
        rdy_cnt = 0;
      end else if (acc) begin
        idx++;
        rdy_cnt++;
      end
      tx_valid = (idx < src_avail);
      tx_data  = (idx < txn_bytes.size()) ? txn_bytes[idx] : 8'h00;
      tx_last  = (idx == txn_bytes.size() - 1);
    end
  end

  // Bit controller + slave model: finish after `latency` go cycles;
  // ACK slot k (0 = address) answers NACK when k == nack_at.
  initial begin
    int lat = 0;
    int slot = 0;
    bit_finish = 1'b0;
    sda_in = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bit_finish = 1'b0;
      sda_in = 1'($urandom);
      if (src_clear) begin
        lat = 0;
        slot = 0;
      end else if (bit_go) begin
        lat++;
        if (lat >= latency) begin
          bit_finish = 1'b1;
          lat = 0;
          if (bit_command == C_NACK) begin
            sda_in = (slot == nack_at);
            slot++;
          end
        end
      end else begin
        lat = 0;
        if (spurious && $urandom_range(0, 3) == 0) bit_finish = 1'b1;
      end
    end
  end

  // Monitor: command order, stability, release and gap, plus status at done.
  bit         p_go = 1'b0, p_fin = 1'b0, p_done = 1'b0, seen_fall = 1'b0;
  logic [2:0] p_cmd = 3'b000;
  int         low_cnt = 0;
  int         pops = 0;
  always @(negedge clock) begin
    logic [2:0] e;
    res_t r;
    if (!mon_en) begin
      exp_cmd_q.delete();
      exp_res_q.delete();
      seen_fall = 1'b0;
      low_cnt = 0;
    end else begin
      if (bit_go && !p_go) begin
        pops++;
        if (exp_cmd_q.size() == 0) begin
          check(1'b0, "cmd_extra", bit_command, 0);
        end else begin
          e = exp_cmd_q.pop_front();
          check(bit_command == e, "cmd_seq", bit_command, e);
        end
        if (seen_fall) check(low_cnt == 1, "gap_cycles", low_cnt, 1);
      end
      if (bit_go && p_go) check(bit_command == p_cmd, "cmd_stable", bit_command, p_cmd);
      if (p_go) check(bit_go == !p_fin, "go_release", bit_go, !p_fin);
      if (!bit_go && p_go) begin
        seen_fall = 1'b1;
        low_cnt = 1;
      end else if (!bit_go) begin
        low_cnt++;
      end
      if (p_done) check(!busy && !done, "busy_fall", {busy, done}, 0);
      if (done) begin
        check(busy, "busy_at_done", busy, 1);
        if (exp_res_q.size() == 0) begin
          check(1'b0, "done_extra", 1, 0);
        end else begin
          r = exp_res_q.pop_front();
          check(ack_error == r.ack_err, "ack_error", ack_error, r.ack_err);
          check(underrun == r.underrun, "underrun", underrun, r.underrun);
          check(rdy_cnt == r.readies, "tx_ready_count", rdy_cnt, r.readies);
          check(exp_cmd_q.size() == 0, "cmds_missing", exp_cmd_q.size(), 0);
        end
        seen_fall = 1'b0;
      end
    end
    p_go = bit_go;
    p_fin = bit_finish;
    p_cmd = bit_command;
    p_done = done;
  end

  // Reference model: expected command stream and status from the protocol rules.
  task automatic model_push(input logic [6:0] a, input int avail, input int nack);
    logic [7:0] ab;
    logic [7:0] d;
    res_t r;
    ab = {a, 1'b0};
    r = '{1'b0, 1'b0, 0};
    exp_cmd_q.push_back(C_START);
    for (int b = 7; b >= 0; b--) exp_cmd_q.push_back(ab[b] ? C_D1 : C_D0);
    exp_cmd_q.push_back(C_NACK);
    if (nack == 0) begin
      r.ack_err = 1'b1;
    end else begin
      for (int i = 0; i < txn_bytes.size(); i++) begin
        if (i >= avail) begin
          r.underrun = 1'b1;
          break;
        end
        r.readies++;
        d = txn_bytes[i];
        for (int b = 7; b >= 0; b--) exp_cmd_q.push_back(d[b] ? C_D1 : C_D0);
        exp_cmd_q.push_back(C_NACK);
        if (nack == i + 1) begin
          r.ack_err = 1'b1;
          break;
        end
      end
    end
    exp_cmd_q.push_back(C_STOP);
    exp_res_q.push_back(r);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check({bit_go, bit_command, tx_ready, busy, done, ack_error, underrun} == 9'd0,
          "reset_async", {bit_go, bit_command, tx_ready, busy, done, ack_error, underrun}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    mon_en = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      check(1'b0, "idle_timeout", busy, 0);
      do_reset();
    end
  endtask

  task automatic launch(input logic [6:0] a, input int avail, input int nack,
                        input int lat, input bit spur);
    wait_idle();
    latency = lat;
    spurious = spur;
    nack_at = nack;
    src_avail = avail;
    @(negedge clock) src_clear = 1'b1;
    @(negedge clock) src_clear = 1'b0;
    model_push(a, avail, nack);
    @(posedge clock);
    #1 start = 1'b1;
    addr = a;
    @(posedge clock);
    #1 start = 1'b0;
    addr = 7'($urandom);
    @(negedge clock);
    check(busy && bit_go, "start_latency", {busy, bit_go}, 3);
    check(!ack_error && !underrun, "flags_cleared", {ack_error, underrun}, 0);
  endtask

  task automatic wait_done(input bit start_on_done);
    bit seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check(seen, "done_seen", seen, 1);
    if (!seen) begin
      do_reset();
    end else if (start_on_done) begin
      start = 1'b1;
      addr = 7'h11;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (3) @(negedge clock);
      check(!busy && !bit_go, "start_at_done_ignored", {busy, bit_go}, 0);
    end
  endtask

  initial begin
    int p0;
    reset_n = 1'b1;
    start = 1'b0;
    addr = 7'h00;
    #1;
    do_reset();

    // Nominal: 0x50 with single last byte 0xA5.
    txn_bytes = '{8'hA5};
    launch(7'h50, 1, -1, 4, 1'b0);
    wait_done(1'b0);

    // Address NACK, plus a start coinciding with done.
    txn_bytes = '{8'h3C, 8'h99};
    launch(7'h2B, 2, 0, 4, 1'b0);
    wait_done(1'b1);

    // Underrun at the second LOAD, slow bit controller.
    txn_bytes = '{8'h00, 8'hFF};
    launch(7'h15, 1, -1, 9, 1'b0);
    wait_done(1'b0);
    repeat (3) @(negedge clock);
    check(underrun, "underrun_hold", underrun, 1);

    // Multi-byte at latency 9 with spurious finish while idle.
    txn_bytes = '{8'h81, 8'h7E, 8'h5A};
    launch(7'h6E, 3, -1, 9, 1'b1);
    wait_done(1'b0);

    // Data NACK on the second byte.
    txn_bytes = '{8'hC3, 8'h24, 8'hE7};
    launch(7'h01, 3, 2, 4, 1'b0);
    wait_done(1'b0);

    // Start with addr 0x7F while busy must not disturb the address in flight.
    txn_bytes = '{8'h96};
    launch(7'h2A, 1, -1, 4, 1'b0);
    repeat (25) @(posedge clock);
    #1 start = 1'b1;
    addr = 7'h7F;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(1'b0);

    // Reset in the middle of the data phase, then a clean transaction.
    txn_bytes = '{8'hF0, 8'h0F};
    p0 = pops;
    launch(7'h33, 2, -1, 4, 1'b0);
    for (int c = 0; c < 3000 && pops < p0 + 13; c++) @(negedge clock);
    check(pops >= p0 + 13, "reach_data_phase", pops - p0, 13);
    do_reset();
    txn_bytes = '{8'h4D};
    launch(7'h50, 1, -1, 4, 1'b0);
    wait_done(1'b0);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      int n;
      int av;
      int nk;
      int lt;
      n = $urandom_range(1, 4);
      av = n;
      nk = -1;
      txn_bytes.delete();
      for (int i = 0; i < n; i++) txn_bytes.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) av = $urandom_range(0, n - 1);
      if ($urandom_range(0, 4) == 0) nk = $urandom_range(0, n);
      case ($urandom_range(0, 3))
        0: lt = 1;
        1: lt = 2;
        2: lt = 4;
        default: lt = 9;
      endcase
      launch(7'($urandom), av, nk, lt, 1'($urandom));
      wait_done(1'b0);
    end

    repeat (4) @(negedge clock);
    check(exp_res_q.size() == 0, "results_left", exp_res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
